// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter that lets four byte requesters share one UART
//   transmitter. A granted byte is latched, written with a single Tx_WR
//   strobe, and the requester is answered with req_ack once the transmitter
//   has gone busy and then idle again. If the transmitter never goes busy
//   within BUSY_TIMEOUT cycles of the write, the requester gets req_err.
//
// Ports
//   give_clk    in   clock, rising edge
//   give_reset  in   asynchronous active-high reset
//   req         in   [3:0]  per-requester level request, held until ack
//   req_data    in   [31:0] byte of requester i on [8i+7:8i]
//   req_ack     out  [3:0]  one-cycle completion pulse to the granted requester
//   req_err     out  [3:0]  one-cycle timeout pulse to the granted requester
//   active_id   out  [1:0]  index of the granted requester
//   arb_busy    out  high whenever a transfer is in progress
//   Tx_DATA     out  [7:0]  latched byte for the transmitter
//   Tx_WR       out  one-cycle transmitter write strobe
//   TX_EN       out  transmitter enable
//   TX_BUSY     in   transmitter busy status
//
// States
//   IDLE      | no transfer; grant the next requester from rr_ptr upward
//   LOAD      | Tx_WR strobe for the latched byte
//   WAIT_BUSY | waiting for TX_BUSY to rise, with timeout
//   WAIT_DONE | transmitter busy, waiting for TX_BUSY to fall
//   DONE      | req_ack pulse, rotate the pointer past the served requester

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic        give_clk,
  input  logic        give_reset,
  input  logic [3:0]  req,
  input  logic [31:0] req_data,
  output logic [3:0]  req_ack,
  output logic [3:0]  req_err,
  output logic [1:0]  active_id,
  output logic        arb_busy,
  output logic [7:0]  Tx_DATA,
  output logic        Tx_WR,
  output logic        TX_EN,
  input  logic        TX_BUSY
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_WAIT_BUSY = 3'd2,
    S_WAIT_DONE = 3'd3,
    S_DONE      = 3'd4
  } state_t;

  localparam logic [7:0] TMO_LAST = 8'(BUSY_TIMEOUT - 1);

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_rr_ptr;
  logic [1:0]  r_active_id;
  logic [7:0]  r_tx_data;
  logic [7:0]  r_wait_cnt;

  logic [1:0]  w_grant_id;
  logic        w_req_any;
  logic        w_timeout;
  logic [3:0]  w_id_onehot;

  assign w_req_any   = |req;
  assign w_id_onehot = 4'b0001 << r_active_id;

  // The timeout fires in the last counted WAIT_BUSY cycle so that req_err
  // lands exactly BUSY_TIMEOUT cycles after the Tx_WR strobe.
  assign w_timeout = (r_state == S_WAIT_BUSY) && !TX_BUSY && (r_wait_cnt == TMO_LAST);

  // Walk offsets from the farthest down to zero so the nearest set bit at or
  // above rr_ptr (with wrap) is the one left standing.
  always_comb begin
    w_grant_id = r_rr_ptr;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req[r_rr_ptr + 2'(i)]) begin
        w_grant_id = r_rr_ptr + 2'(i);
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:      if (w_req_any) w_next = S_LOAD;
      S_LOAD:      w_next = S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (TX_BUSY)        w_next = S_WAIT_DONE;
        else if (w_timeout) w_next = S_IDLE;
      end
      S_WAIT_DONE: if (!TX_BUSY) w_next = S_DONE;
      S_DONE:      w_next = S_IDLE;
      default:     w_next = S_IDLE;
    endcase
  end

  // Outputs decode straight from the state register so an asynchronous
  // reset takes them to their idle values in the same cycle.
  always_comb begin
    Tx_WR    = (r_state == S_LOAD);
    TX_EN    = (r_state != S_IDLE);
    arb_busy = (r_state != S_IDLE);
    req_ack  = (r_state == S_DONE) ? w_id_onehot : 4'b0000;
    req_err  = w_timeout ? w_id_onehot : 4'b0000;
  end

  assign active_id = r_active_id;
  assign Tx_DATA   = r_tx_data;

  always_ff @(posedge give_clk or posedge give_reset) begin
    if (give_reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= 2'd0;
      r_active_id <= 2'd0;
      r_tx_data   <= 8'h00;
      r_wait_cnt  <= 8'd0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_req_any) begin
            r_active_id <= w_grant_id;
            r_tx_data   <= req_data[{w_grant_id, 3'b000} +: 8];
          end
        end
        S_LOAD: r_wait_cnt <= 8'd0;
        S_WAIT_BUSY: begin
          if (w_timeout) begin
            r_rr_ptr <= r_active_id + 2'd1;
          end else if (!TX_BUSY) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
          end
        end
        S_DONE: r_rr_ptr <= r_active_id + 2'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter: NUM_REQ, 4, number of byte requesters; fixed at 4 in this revision.
REQ-002 Parameter: BUSY_TIMEOUT, 64, maximum give_clk cycles to wait for TX_BUSY to rise after the Tx_WR pulse.
REQ-003 give_clk  input  1  single clock; all state changes on its rising edge.
REQ-004 give_reset  input  1  reset, asynchronous, active-high.
REQ-005 req  input  4  per-requester transmit request, level, held until ack.
REQ-006 req_data  input  32  byte of requester i on bits [8i+7:8i].
REQ-007 req_ack  output  4  one-cycle pulse to the requester whose byte completed.
REQ-008 req_err  output  4  one-cycle pulse to the requester whose transfer timed out.
REQ-009 active_id  output  2  index of the currently granted requester.
REQ-010 arb_busy  output  1  high whenever the state is not IDLE.
REQ-011 Tx_DATA  output  8  byte presented to the UART transmitter.
REQ-012 Tx_WR  output  1  one-cycle write strobe to the transmitter.
REQ-013 TX_EN  output  1  transmitter enable.
REQ-014 TX_BUSY  input  1  transmitter busy status.

Function
REQ-015 The block SHALL implement states IDLE, LOAD, WAIT_BUSY, WAIT_DONE, DONE.
REQ-016 IDLE: with any req bit high, the block SHALL grant the first set bit searching upward from rr_ptr with wrap-around (3 wraps to 0), latch its byte and index, and enter LOAD on the next edge.
REQ-017 LOAD: the block SHALL assert Tx_WR for exactly one cycle, then enter WAIT_BUSY.
REQ-018 Tx_DATA SHALL hold the latched byte, stable from LOAD through DONE; requester data changes after the grant SHALL be ignored.
REQ-019 TX_EN SHALL be high in LOAD, WAIT_BUSY, WAIT_DONE and DONE, and low in IDLE.
REQ-020 WAIT_BUSY: with TX_BUSY=1, the block SHALL enter WAIT_DONE; otherwise it SHALL increment an 8-bit wait counter (cleared on entry).
REQ-021 When the wait counter reaches BUSY_TIMEOUT-1 with TX_BUSY still 0, the block SHALL pulse req_err[active_id] for one cycle, set rr_ptr=active_id+1 mod 4, and return to IDLE.
REQ-022 WAIT_DONE: with TX_BUSY=0, the block SHALL enter DONE; there is no timeout in this state.
REQ-023 DONE: the block SHALL pulse req_ack[active_id] for one cycle, set rr_ptr=active_id+1 mod 4, and return to IDLE.
REQ-024 A new grant SHALL NOT be issued in the cycle req_ack or req_err is high; the earliest next LOAD is two cycles after DONE.
REQ-025 Deassertion of the granted req mid-transfer SHALL NOT abort the transfer; ack SHALL still pulse.
REQ-026 req_ack and req_err SHALL be one-hot or zero, and never both nonzero in the same cycle.
REQ-027 With all four requesters continuously requesting, the grant order SHALL be strictly rotating, so no requester waits more than 3 transfers.

Reset
REQ-028 give_reset high SHALL immediately force state=IDLE, rr_ptr=0, active_id=0, Tx_DATA=8'h00, Tx_WR=0, TX_EN=0, req_ack=0, req_err=0, arb_busy=0, and wait counter=0, regardless of the current state.
REQ-029 A transfer interrupted by reset SHALL NOT produce an ack or err after reset release.
REQ-030 The first grant after reset release SHALL follow REQ-016 with rr_ptr=0.

Verification
REQ-031 Single request: req=4'b0100 with byte 8'hA5, transmitter model raises TX_BUSY 3 cycles after Tx_WR and holds it 20 cycles -> one Tx_WR pulse with Tx_DATA=8'hA5, then req_ack=4'b0100 for one cycle, then rr_ptr=3.
REQ-032 All simultaneous: req=4'b1111 after reset, bytes 11/22/33/44 -> Tx_DATA sequence 8'h11, 8'h22, 8'h33, 8'h44, with acks in order 0,1,2,3.
REQ-033 Wrap fairness: after requester 1 is served, req=4'b0101 -> requester 2 is served first, then requester 0.
REQ-034 Timeout: TX_BUSY tied 0, req=4'b0001 -> req_err=4'b0001 exactly 64 cycles after the Tx_WR pulse, no ack, state returns to IDLE.
REQ-035 Reset mid-transfer: assert give_reset during WAIT_DONE -> all outputs are at reset values within the same cycle, and no ack follows release.
REQ-036 Data stability: change req_data of the granted requester during WAIT_DONE -> Tx_DATA stays unchanged until DONE.
